// File: rtl/mdio_pkg.sv
// mdio_pkg: shared state encoding, opcodes and register reset values for the MDIO responder.
package mdio_pkg;

  typedef enum logic [2:0] {IDLE, ST, OP, PHYAD, REGAD, TA, DATA} mdio_state_e;

  localparam logic [1:0] OP_RD = 2'b10;
  localparam logic [1:0] OP_WR = 2'b01;
  localparam logic [1:0] TA_WR = 2'b10;

  function automatic logic [15:0] reg_init(input int p, input int r);
    return {p[7:0], 3'b000, r[4:0]};
  endfunction

endpackage

// File: rtl/mdio_sync_edge.sv
// mdio_sync_edge: synchronises mdc/mdio into board_clk and flags mdc rise/fall one cycle later.
module mdio_sync_edge #(
  parameter int SyncStages = 2
) (
  input  logic board_clk,
  input  logic rst_n,
  input  logic mdc,
  input  logic mdio,
  output logic mdc_rise,
  output logic mdc_fall,
  output logic mdio_lvl
);

  logic [SyncStages-1:0] mdc_q;
  logic [SyncStages-1:0] mdio_q;
  logic                  mdc_d;

  always_ff @(posedge board_clk or negedge rst_n)
    if (!rst_n) begin
      mdc_q  <= '0;
      mdio_q <= '1;
      mdc_d  <= 1'b0;
    end else begin
      mdc_q  <= {mdc_q[SyncStages-2:0], mdc};
      mdio_q <= {mdio_q[SyncStages-2:0], mdio};
      mdc_d  <= mdc_q[SyncStages-1];
    end

  assign mdc_rise = mdc_q[SyncStages-1] & ~mdc_d;
  assign mdc_fall = ~mdc_q[SyncStages-1] & mdc_d;
  assign mdio_lvl = mdio_q[SyncStages-1];

endmodule

// File: rtl/mdio_phy_responder.sv
// mdio_phy_responder: Clause-22 MDIO PHY emulator with per-PHY register files and a host side-port.
module mdio_phy_responder
  import mdio_pkg::*;
#(
  parameter int          NumPhys     = 1,
  parameter logic [4:0]  PhyBaseAddr = 5'd0,
  parameter int          NumRegs     = 32,
  parameter int          PreambleMin = 32,
  parameter int          SyncStages  = 2,
  parameter logic [31:0] RoMask      = 32'h0
) (
  input  logic                                         board_clk,
  input  logic                                         rst_n,
  input  logic                                         mdc_i,
  input  logic                                         mdio_i,
  output logic                                         mdio_o,
  output logic                                         mdio_oe_o,
  input  logic                                         hreg_wr_i,
  input  logic [$clog2(NumPhys > 1 ? NumPhys : 2)-1:0] hreg_phy_i,
  input  logic [4:0]                                   hreg_addr_i,
  input  logic [15:0]                                  hreg_wdata_i,
  output logic [15:0]                                  hreg_rdata_o,
  output logic                                         frame_done_o,
  output logic                                         frame_err_o,
  output logic [7:0]                                   err_cnt_o
);

  localparam int HW  = $clog2(NumPhys > 1 ? NumPhys : 2);
  localparam int PcW = $clog2(PreambleMin + 2);

  mdio_state_e     state;
  logic [4:0]      cnt;
  logic [PcW-1:0]  pre_cnt;
  logic            op_b;
  logic [4:0]      phyad;
  logic [4:0]      regad;
  logic            is_rd;
  logic [15:0]     rd_sh;
  logic [15:0]     wr_sh;
  logic            commit;
  logic [4:0]      phy_off;
  logic            hit;
  logic            drv;
  logic [15:0]     mdio_rd;
  logic [15:0]     host_rd;
  logic [15:0]     regs [NumPhys][NumRegs];
  logic            mdc_rise;
  logic            mdc_fall;
  logic            mdio_lvl;

  mdio_sync_edge #(.SyncStages(SyncStages)) u_sync (
    .board_clk(board_clk),
    .rst_n    (rst_n),
    .mdc      (mdc_i),
    .mdio     (mdio_i),
    .mdc_rise (mdc_rise),
    .mdc_fall (mdc_fall),
    .mdio_lvl (mdio_lvl)
  );

  assign phy_off = phyad - PhyBaseAddr;
  assign hit     = int'(phy_off) < NumPhys;
  // Drive from the fall after the first TA bit until the fall after the last data rise.
  assign drv     = hit & is_rd & (state == DATA || (state == TA && cnt == 5'd1));

  // Unimplemented PHYs/registers read as all-ones.
  always_comb begin
    mdio_rd = 16'hFFFF;
    host_rd = 16'hFFFF;
    for (int p = 0; p < NumPhys; p++)
      for (int r = 0; r < NumRegs; r++) begin
        if (5'(p) == phy_off && 5'(r) == regad) mdio_rd = regs[p][r];
        if (HW'(p) == hreg_phy_i && 5'(r) == hreg_addr_i) host_rd = regs[p][r];
      end
  end

  // Host port outranks an MDIO commit to the same register; RoMask only gates MDIO.
  always_ff @(posedge board_clk or negedge rst_n)
    if (!rst_n) begin
      for (int p = 0; p < NumPhys; p++)
        for (int r = 0; r < NumRegs; r++)
          regs[p][r] <= reg_init(p, r);
    end else begin
      for (int p = 0; p < NumPhys; p++)
        for (int r = 0; r < NumRegs; r++)
          if (hreg_wr_i && HW'(p) == hreg_phy_i && 5'(r) == hreg_addr_i)
            regs[p][r] <= hreg_wdata_i;
          else if (commit && 5'(p) == phy_off && 5'(r) == regad && !RoMask[r])
            regs[p][r] <= wr_sh;
    end

  always_ff @(posedge board_clk or negedge rst_n)
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      pre_cnt      <= '0;
      op_b         <= 1'b0;
      phyad        <= '0;
      regad        <= '0;
      is_rd        <= 1'b0;
      rd_sh        <= '0;
      wr_sh        <= '0;
      commit       <= 1'b0;
      mdio_o       <= 1'b1;
      mdio_oe_o    <= 1'b0;
      hreg_rdata_o <= '0;
      frame_done_o <= 1'b0;
      frame_err_o  <= 1'b0;
      err_cnt_o    <= '0;
    end else begin
      frame_done_o <= 1'b0;
      frame_err_o  <= 1'b0;
      commit       <= 1'b0;
      hreg_rdata_o <= host_rd;
      if (frame_err_o && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
      if (mdc_rise)
        case (state)
          IDLE:
            if (mdio_lvl) pre_cnt <= (pre_cnt >= PcW'(PreambleMin)) ? pre_cnt : pre_cnt + 1'b1;
            else begin
              pre_cnt <= '0;
              if (pre_cnt >= PcW'(PreambleMin)) state <= ST;
            end
          ST:
            if (mdio_lvl) begin
              state <= OP;
              cnt   <= '0;
            end else begin
              frame_err_o <= 1'b1;
              state       <= IDLE;
            end
          OP: begin
            op_b <= mdio_lvl;
            cnt  <= cnt + 5'd1;
            if (cnt == 5'd1) begin
              cnt <= '0;
              if ({op_b, mdio_lvl} == OP_RD || {op_b, mdio_lvl} == OP_WR) begin
                state <= PHYAD;
                is_rd <= {op_b, mdio_lvl} == OP_RD;
              end else begin
                frame_err_o <= 1'b1;
                state       <= IDLE;
              end
            end
          end
          PHYAD: begin
            phyad <= {phyad[3:0], mdio_lvl};
            cnt   <= (cnt == 5'd4) ? 5'd0 : cnt + 5'd1;
            if (cnt == 5'd4) state <= REGAD;
          end
          REGAD: begin
            regad <= {regad[3:0], mdio_lvl};
            cnt   <= (cnt == 5'd4) ? 5'd0 : cnt + 5'd1;
            if (cnt == 5'd4) state <= TA;
          end
          TA:
            if (cnt == 5'd0) begin
              rd_sh <= mdio_rd;
              cnt   <= 5'd1;
              if (!is_rd && mdio_lvl != TA_WR[1]) begin
                frame_err_o <= 1'b1;
                state       <= IDLE;
              end
            end else begin
              cnt <= '0;
              if (!is_rd && mdio_lvl != TA_WR[0]) begin
                frame_err_o <= 1'b1;
                state       <= IDLE;
              end else state <= DATA;
            end
          DATA: begin
            wr_sh <= {wr_sh[14:0], mdio_lvl};
            cnt   <= cnt + 5'd1;
            if (cnt == 5'd15) begin
              state        <= IDLE;
              cnt          <= '0;
              pre_cnt      <= '0;
              frame_done_o <= hit;
              commit       <= hit & ~is_rd;
            end
          end
          default: state <= IDLE;
        endcase
      if (mdc_fall) begin
        mdio_oe_o <= drv;
        mdio_o    <= ~drv | (state == DATA && rd_sh[~cnt[3:0]]);
      end
    end

endmodule

// File: tb/tb_mdio_phy_responder.sv
// tb_mdio_phy_responder: directed MDIO frames against two responder configurations.
module tb_mdio_phy_responder;

  logic        board_clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic        mdc       = 1'b0;
  logic        mdio      = 1'b1;
  logic        hwr0      = 1'b0;
  logic        hwr1      = 1'b0;
  logic        hphy      = 1'b0;
  logic [4:0]  haddr     = '0;
  logic [15:0] hwd       = '0;

  logic        o0, oe0, done0, err0, o1, oe1, done1, err1;
  logic [15:0] rd0, rd1;
  logic [7:0]  ec0, ec1;

  always #5 board_clk = ~board_clk;

  mdio_phy_responder u0 (
    .board_clk(board_clk), .rst_n(rst_n), .mdc_i(mdc), .mdio_i(mdio),
    .mdio_o(o0), .mdio_oe_o(oe0), .hreg_wr_i(hwr0), .hreg_phy_i(hphy),
    .hreg_addr_i(haddr), .hreg_wdata_i(hwd), .hreg_rdata_o(rd0),
    .frame_done_o(done0), .frame_err_o(err0), .err_cnt_o(ec0)
  );

  mdio_phy_responder #(
    .NumPhys(2), .PhyBaseAddr(5'd1), .NumRegs(16), .RoMask(32'h0000_0010)
  ) u1 (
    .board_clk(board_clk), .rst_n(rst_n), .mdc_i(mdc), .mdio_i(mdio),
    .mdio_o(o1), .mdio_oe_o(oe1), .hreg_wr_i(hwr1), .hreg_phy_i(hphy),
    .hreg_addr_i(haddr), .hreg_wdata_i(hwd), .hreg_rdata_o(rd1),
    .frame_done_o(done1), .frame_err_o(err1), .err_cnt_o(ec1)
  );

  int checks = 0;
  int errors = 0;
  int done_c0 = 0, done_c1 = 0, err_c0 = 0;
  int d0, d1, x0;

  always @(posedge board_clk) begin
    if (done0) done_c0 <= done_c0 + 1;
    if (done1) done_c1 <= done_c1 + 1;
    if (err0) err_c0 <= err_c0 + 1;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  logic        s0, e0, s1, e1, any0, any1;
  logic        ta1_oe0, ta2_oe0, ta2_o0, doe0, doe1, post_oe0;
  logic [15:0] rdv0, rdv1;

  // One MDC period: MAC changes mdio with the fall and samples the PHY just before the rise.
  task automatic mbit(input logic b);
    mdc  = 1'b0;
    mdio = b;
    repeat (8) @(negedge board_clk);
    s0 = o0; e0 = oe0; s1 = o1; e1 = oe1;
    mdc = 1'b1;
    repeat (8) @(negedge board_clk);
  endtask

  task automatic xfer(input int pre, input logic [31:0] f, input int nbits);
    any0 = 1'b0; any1 = 1'b0; doe0 = 1'b1; doe1 = 1'b1;
    repeat (pre) mbit(1'b1);
    for (int i = 0; i < nbits; i++) begin
      mbit(f[31-i]);
      any0 |= e0;
      any1 |= e1;
      if (i == 14) ta1_oe0 = e0;
      if (i == 15) begin ta2_oe0 = e0; ta2_o0 = s0; end
      if (i >= 16) begin
        rdv0[31-i] = s0;
        rdv1[31-i] = s1;
        doe0 &= e0;
        doe1 &= e1;
      end
    end
    if (nbits == 32) begin
      mbit(1'b1);
      post_oe0 = e0;
    end
  endtask

  function automatic logic [31:0] rdf(input logic [4:0] pa, input logic [4:0] ra);
    return {2'b01, 2'b10, pa, ra, 2'b11, 16'hFFFF};
  endfunction

  function automatic logic [31:0] wrf(input logic [4:0] pa, input logic [4:0] ra, input logic [15:0] d);
    return {2'b01, 2'b01, pa, ra, 2'b10, d};
  endfunction

  task automatic hread(input logic p, input logic [4:0] a);
    @(negedge board_clk);
    hphy = p; haddr = a;
    @(negedge board_clk);
  endtask

  task automatic hwrite0(input logic p, input logic [4:0] a, input logic [15:0] d);
    @(negedge board_clk);
    hphy = p; haddr = a; hwd = d; hwr0 = 1'b1;
    @(negedge board_clk);
    hwr0 = 1'b0;
  endtask

  initial begin
    repeat (3) @(negedge board_clk);
    chk("rst_oe", 16'(oe0), 16'd0);
    chk("rst_mdio", 16'(o0), 16'd1);
    chk("rst_rdata", rd0, 16'h0000);
    chk("rst_errcnt", 16'(ec0), 16'd0);
    chk("rst_done", 16'(done0), 16'd0);
    rst_n = 1'b1;
    @(negedge board_clk);

    hread(1'b0, 5'd3);
    chk("t1_host_r3", rd0, 16'h0003);
    d0 = done_c0;
    xfer(32, rdf(5'd0, 5'd3), 32);
    chk("t1_ta1_oe", 16'(ta1_oe0), 16'd0);
    chk("t1_ta2_oe", 16'(ta2_oe0), 16'd1);
    chk("t1_ta2_mdio", 16'(ta2_o0), 16'd0);
    chk("t1_data", rdv0, 16'h0003);
    chk("t1_data_oe", 16'(doe0), 16'd1);
    chk("t1_post_oe", 16'(post_oe0), 16'd0);
    chk("t1_done", 16'(done_c0 - d0), 16'd1);

    d0 = done_c0;
    xfer(32, wrf(5'd0, 5'd4, 16'hBEEF), 32);
    chk("t2_wr_done", 16'(done_c0 - d0), 16'd1);
    chk("t2_wr_no_oe", 16'(any0), 16'd0);
    hread(1'b0, 5'd4);
    chk("t2_host_r4", rd0, 16'hBEEF);
    xfer(32, rdf(5'd0, 5'd4), 32);
    chk("t2_rd_r4", rdv0, 16'hBEEF);
    xfer(32, wrf(5'd1, 5'd4, 16'hBEEF), 32);
    xfer(32, rdf(5'd1, 5'd4), 32);
    chk("t2_ro_r4", rdv1, 16'h0004);

    d0 = done_c0; d1 = done_c1;
    xfer(32, rdf(5'd2, 5'd1), 32);
    chk("t3_phy2_r1", rdv1, 16'h0101);
    chk("t3_phy2_oe", 16'(doe1), 16'd1);
    chk("t3_u0_quiet", 16'(any0), 16'd0);
    chk("t3_phy2_done", 16'(done_c1 - d1), 16'd1);
    d0 = done_c0; d1 = done_c1;
    xfer(32, rdf(5'd7, 5'd1), 32);
    chk("t3_phy7_oe", 16'(any1 | any0), 16'd0);
    chk("t3_phy7_done", 16'(done_c1 - d1 + done_c0 - d0), 16'd0);

    x0 = err_c0;
    xfer(32, {2'b01, 2'b11, 5'd0, 5'd3, 2'b11, 16'hFFFF}, 32);
    chk("t4_op11_err", 16'(err_c0 - x0), 16'd1);
    chk("t4_op11_cnt", 16'(ec0), 16'd1);
    xfer(32, rdf(5'd0, 5'd3), 32);
    chk("t4_op11_recover", rdv0, 16'h0003);
    x0 = err_c0;
    xfer(32, {2'b01, 2'b01, 5'd0, 5'd5, 2'b11, 16'hDEAD}, 32);
    chk("t4_ta_err", 16'(err_c0 - x0), 16'd1);
    chk("t4_ta_cnt", 16'(ec0), 16'd2);
    hread(1'b0, 5'd5);
    chk("t4_ta_nowrite", rd0, 16'h0005);
    xfer(32, rdf(5'd0, 5'd3), 32);
    chk("t4_ta_recover", rdv0, 16'h0003);
    x0 = err_c0;
    xfer(32, {2'b00, 2'b10, 5'd0, 5'd3, 2'b11, 16'hFFFF}, 32);
    chk("t4_st_err", 16'(err_c0 - x0), 16'd1);
    chk("t4_st_cnt", 16'(ec0), 16'd3);
    xfer(32, rdf(5'd0, 5'd3), 32);
    chk("t4_st_recover", rdv0, 16'h0003);
    x0 = err_c0; d0 = done_c0;
    xfer(10, rdf(5'd0, 5'd3), 32);
    chk("t4_short_noerr", 16'(err_c0 - x0), 16'd0);
    chk("t4_short_nodone", 16'(done_c0 - d0), 16'd0);
    chk("t4_short_nooe", 16'(any0), 16'd0);
    chk("t4_short_cnt", 16'(ec0), 16'd3);
    xfer(32, rdf(5'd0, 5'd3), 32);
    chk("t4_short_recover", rdv0, 16'h0003);

    fork
      xfer(32, wrf(5'd0, 5'd1, 16'h5678), 32);
      begin
        for (int k = 0; k < 3000 && !done0; k++) @(negedge board_clk);
        if (!done0) chk("t5_done_seen", 16'(done0), 16'd1);
        else begin
          hphy = 1'b0; haddr = 5'd1; hwd = 16'h1234; hwr0 = 1'b1;
          @(negedge board_clk);
          hwr0 = 1'b0;
        end
      end
    join
    hread(1'b0, 5'd1);
    chk("t5_host_wins", rd0, 16'h1234);
    xfer(32, rdf(5'd1, 5'd31), 32);
    chk("t5_unimpl_rd", rdv1, 16'hFFFF);
    d1 = done_c1;
    xfer(32, wrf(5'd1, 5'd20, 16'h5555), 32);
    chk("t5_unimpl_wr_done", 16'(done_c1 - d1), 16'd1);

    hwrite0(1'b0, 5'd3, 16'hAAAA);
    hread(1'b0, 5'd3);
    chk("t6_host_r3", rd0, 16'hAAAA);
    xfer(32, rdf(5'd0, 5'd3), 24);
    chk("t6_mid_oe", 16'(e0), 16'd1);
    chk("t6_mid_bits", {8'h00, rdv0[15:8]}, 16'h00AA);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_oe", 16'(oe0), 16'd0);
    chk("t6_rst_mdio", 16'(o0), 16'd1);
    repeat (2) @(negedge board_clk);
    rst_n = 1'b1;
    hread(1'b0, 5'd3);
    chk("t6_rst_r3", rd0, 16'h0003);
    hread(1'b0, 5'd1);
    chk("t6_rst_r1", rd0, 16'h0001);
    chk("t6_rst_errcnt", 16'(ec0), 16'd0);
    d0 = done_c0;
    xfer(32, rdf(5'd0, 5'd3), 32);
    chk("t6_after_rd", rdv0, 16'h0003);
    chk("t6_after_done", 16'(done_c0 - d0), 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
